// File: rtl/host_mem_responder_if.sv
// host_mem_responder_if: channel-0 line read and channel-1 line write bus between AFU and host memory
interface host_mem_responder_if #(parameter int ADDR_BITS = 6);
  logic c0_req_valid;
  logic [ADDR_BITS-1:0] c0_req_addr;
  logic [15:0] c0_req_mdata;
  logic c0_almfull;
  logic c0_rsp_valid;
  logic [511:0] c0_rsp_data;
  logic [15:0] c0_rsp_mdata;
  logic c1_req_valid;
  logic [ADDR_BITS-1:0] c1_req_addr;
  logic [15:0] c1_req_mdata;
  logic [511:0] c1_req_data;
  logic c1_almfull;
  logic c1_rsp_valid;
  logic [15:0] c1_rsp_mdata;
  modport master (
    output c0_req_valid, c0_req_addr, c0_req_mdata, c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    input c0_almfull, c0_rsp_valid, c0_rsp_data, c0_rsp_mdata, c1_almfull, c1_rsp_valid, c1_rsp_mdata
  );
  modport slave (
    input c0_req_valid, c0_req_addr, c0_req_mdata, c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
    output c0_almfull, c0_rsp_valid, c0_rsp_data, c0_rsp_mdata, c1_almfull, c1_rsp_valid, c1_rsp_mdata
  );
endinterface

// File: rtl/host_mem_responder.sv
// host_mem_responder: host memory model serving line reads/writes with fixed-latency in-order responses
module host_mem_responder #(
  parameter int ADDR_BITS = 6,
  parameter int RD_LATENCY = 8,
  parameter int WR_LATENCY = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ALMFULL_THRESH = 3
) (
  input  logic clk,
  input  logic reset,
  host_mem_responder_if.slave bus,
  input  logic bd_wr_en,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [511:0] bd_wr_data,
  output logic [511:0] bd_rd_data,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [1:0] overflow
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] THR_C = CW'(ALMFULL_THRESH);
  logic [511:0] mem [2**ADDR_BITS];
  logic rd_acc, rd_drop, wr_acc, wr_drop;
  logic [511:0] rd_line;
  logic [CW-1:0] rd_inflight_q, rd_inflight_d, wr_inflight_q, wr_inflight_d;
  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [RD_LATENCY-1:0][15:0] rd_tag_q, rd_tag_d, rd_tag_s;
  logic [RD_LATENCY-1:0][511:0] rd_dat_q, rd_dat_d, rd_dat_s;
  logic [WR_LATENCY-1:0] wr_vld_q, wr_vld_d;
  logic [WR_LATENCY-1:0][15:0] wr_tag_q, wr_tag_d, wr_tag_s;
  logic [31:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic [1:0] overflow_q, overflow_d;
  logic [511:0] bd_rd_data_q, bd_rd_data_d;
  always_comb begin
    rd_acc = !reset && bus.c0_req_valid && rd_inflight_q < MAX_C;
    rd_drop = !reset && bus.c0_req_valid && !rd_acc;
    wr_acc = !reset && bus.c1_req_valid && wr_inflight_q < MAX_C;
    wr_drop = !reset && bus.c1_req_valid && !wr_acc;
    rd_line = mem[bus.c0_req_addr];
    bd_rd_data_d = mem[bd_addr];
    rd_inflight_d = rd_inflight_q + CW'(rd_acc) - CW'(rd_vld_q[RD_LATENCY-1]);
    wr_inflight_d = wr_inflight_q + CW'(wr_acc) - CW'(wr_vld_q[WR_LATENCY-1]);
    rd_count_d = rd_count_q + 32'(rd_acc);
    wr_count_d = wr_count_q + 32'(wr_acc);
    overflow_d = overflow_q | {wr_drop, rd_drop};
    rd_vld_d = RD_LATENCY'({rd_vld_q, rd_acc});
    rd_tag_s = (RD_LATENCY*16)'({rd_tag_q, bus.c0_req_mdata});
    rd_dat_s = (RD_LATENCY*512)'({rd_dat_q, rd_line});
    wr_vld_d = WR_LATENCY'({wr_vld_q, wr_acc});
    wr_tag_s = (WR_LATENCY*16)'({wr_tag_q, bus.c1_req_mdata});
    for (int i = 0; i < RD_LATENCY; i++) begin
      rd_tag_d[i] = rd_vld_d[i] ? rd_tag_s[i] : rd_tag_q[i];
      rd_dat_d[i] = rd_vld_d[i] ? rd_dat_s[i] : rd_dat_q[i];
    end
    for (int i = 0; i < WR_LATENCY; i++) wr_tag_d[i] = wr_vld_d[i] ? wr_tag_s[i] : wr_tag_q[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_inflight_q <= '0;
      wr_inflight_q <= '0;
      rd_vld_q <= '0;
      rd_tag_q <= '0;
      rd_dat_q <= '0;
      wr_vld_q <= '0;
      wr_tag_q <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      overflow_q <= '0;
      bd_rd_data_q <= '0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      wr_inflight_q <= wr_inflight_d;
      rd_vld_q <= rd_vld_d;
      rd_tag_q <= rd_tag_d;
      rd_dat_q <= rd_dat_d;
      wr_vld_q <= wr_vld_d;
      wr_tag_q <= wr_tag_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
      bd_rd_data_q <= bd_rd_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (bd_wr_en) mem[bd_addr] <= bd_wr_data;
    if (wr_acc) mem[bus.c1_req_addr] <= bus.c1_req_data;
  end
  assign bus.c0_rsp_valid = rd_vld_q[RD_LATENCY-1];
  assign bus.c0_rsp_mdata = rd_tag_q[RD_LATENCY-1];
  assign bus.c0_rsp_data = rd_dat_q[RD_LATENCY-1];
  assign bus.c1_rsp_valid = wr_vld_q[WR_LATENCY-1];
  assign bus.c1_rsp_mdata = wr_tag_q[WR_LATENCY-1];
  assign bus.c0_almfull = rd_inflight_q >= THR_C;
  assign bus.c1_almfull = wr_inflight_q >= THR_C;
  assign bd_rd_data = bd_rd_data_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
  assign overflow = overflow_q;
endmodule
